// File: rtl/modadd_sched.sv
// Two-requester round-robin front end feeding a 3-stage modular add/subtract
// pipeline; every stage freezes together while the output is back-pressured.
module modadd_sched #(
   parameter int W   = 4,
   parameter int MOD = 11
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         r0_valid,
   output logic         r0_ready,
   input  logic         r0_s,
   input  logic [W-1:0] r0_x,
   input  logic [W-1:0] r0_y,
   input  logic         r1_valid,
   output logic         r1_ready,
   input  logic         r1_s,
   input  logic [W-1:0] r1_x,
   input  logic [W-1:0] r1_y,
   output logic         z_valid,
   input  logic         z_ready,
   output logic [W-1:0] z,
   output logic         z_tag,
   output logic         z_err
);

   if ((MOD < 2) || (MOD > (1 << W))) begin : g_mod_check
      $error("modadd_sched: MOD must satisfy 2 <= MOD <= 2**W");
   end

   localparam logic [W:0] MOD_V = (W+1)'(MOD);

   logic         adv, g0, g1;
   logic         ptr_q;
   logic         sel_s;
   logic [W-1:0] sel_x, sel_y;

   logic         v1_q, s1_q, tag1_q, err1_q;
   logic [W:0]   t1_q, t1_d;
   logic         err1_d;

   logic         v2_q, s2_q, tag2_q, err2_q;
   logic [W:0]   t2_q;
   logic [W-1:0] c2_q, c2_d;

   logic         z_valid_q, z_tag_q, z_err_q;
   logic [W-1:0] z_q, z_d;
   logic         pick_c;

   // ptr_q = 0 favours requester 0 when both are valid
   always_comb begin
      adv = !z_valid_q || z_ready;
      g0  = !rst && adv && r0_valid && (!r1_valid || !ptr_q);
      g1  = !rst && adv && r1_valid && (!r0_valid ||  ptr_q);

      sel_s = g1 ? r1_s : r0_s;
      sel_x = g1 ? r1_x : r0_x;
      sel_y = g1 ? r1_y : r0_y;

      t1_d   = sel_s ? ({1'b0, sel_x} - {1'b0, sel_y})
                     : ({1'b0, sel_x} + {1'b0, sel_y});
      err1_d = ({1'b0, sel_x} >= MOD_V) || ({1'b0, sel_y} >= MOD_V);

      // only the low W bits of the correction can ever be selected
      c2_d = s1_q ? (t1_q[W-1:0] + MOD_V[W-1:0]) : (t1_q[W-1:0] - MOD_V[W-1:0]);

      pick_c = s2_q ? t2_q[W] : (t2_q >= MOD_V);
      z_d    = err2_q ? '0 : (pick_c ? c2_q : t2_q[W-1:0]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q     <= 1'b0;
         v1_q      <= 1'b0;
         s1_q      <= 1'b0;
         tag1_q    <= 1'b0;
         err1_q    <= 1'b0;
         t1_q      <= '0;
         v2_q      <= 1'b0;
         s2_q      <= 1'b0;
         tag2_q    <= 1'b0;
         err2_q    <= 1'b0;
         t2_q      <= '0;
         c2_q      <= '0;
         z_valid_q <= 1'b0;
         z_q       <= '0;
         z_tag_q   <= 1'b0;
         z_err_q   <= 1'b0;
      end else begin
         if (g0 || g1) begin
            ptr_q <= g0;
         end
         if (adv) begin
            v1_q      <= g0 || g1;
            s1_q      <= sel_s;
            tag1_q    <= g1;
            err1_q    <= err1_d;
            t1_q      <= t1_d;
            v2_q      <= v1_q;
            s2_q      <= s1_q;
            tag2_q    <= tag1_q;
            err2_q    <= err1_q;
            t2_q      <= t1_q;
            c2_q      <= c2_d;
            z_valid_q <= v2_q;
            z_q       <= z_d;
            z_tag_q   <= tag2_q;
            z_err_q   <= err2_q;
         end
      end
   end

   assign r0_ready = g0;
   assign r1_ready = g1;
   assign z_valid  = z_valid_q;
   assign z        = z_q;
   assign z_tag    = z_tag_q;
   assign z_err    = z_err_q;

endmodule

// File: tb/tb_modadd_sched.sv
// Directed bench for modadd_sched (W=4, MOD=11): vector table plus hand-written
// contention, backpressure and reset sequences.
module tb_modadd_sched;
   localparam int W   = 4;
   localparam int MOD = 11;
   localparam int N   = 13;

   logic         clk = 1'b0;
   logic         rst;
   logic         r0_valid, r0_ready, r0_s;
   logic [W-1:0] r0_x, r0_y;
   logic         r1_valid, r1_ready, r1_s;
   logic [W-1:0] r1_x, r1_y;
   logic         z_valid, z_ready, z_tag, z_err;
   logic [W-1:0] z;

   int tests_run = 0;
   int fails     = 0;

   typedef struct {
      int tag;
      int s;
      int x;
      int y;
      int z;
      int err;
   } vec_t;

   vec_t vecs [N];

   modadd_sched #(.W(W), .MOD(MOD)) dut (
      .clk(clk), .rst(rst),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_s(r0_s), .r0_x(r0_x), .r0_y(r0_y),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_s(r1_s), .r1_x(r1_x), .r1_y(r1_y),
      .z_valid(z_valid), .z_ready(z_ready), .z(z), .z_tag(z_tag), .z_err(z_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input int exp);
      tests_run++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      r0_valid = 1'b0; r0_s = 1'b0; r0_x = '0; r0_y = '0;
      r1_valid = 1'b0; r1_s = 1'b0; r1_x = '0; r1_y = '0;
   endtask

   task automatic drive(input int r, input int s, input int x, input int y);
      if (r == 0) begin
         r0_valid = 1'b1; r0_s = s[0]; r0_x = x[W-1:0]; r0_y = y[W-1:0];
      end else begin
         r1_valid = 1'b1; r1_s = s[0]; r1_x = x[W-1:0]; r1_y = y[W-1:0];
      end
   endtask

   task automatic chk_z(input string nm, input int zv, input int tg, input int er);
      chk({nm, " z_valid"}, z_valid, 1);
      chk({nm, " z"}, z, zv);
      chk({nm, " z_tag"}, z_tag, tg);
      chk({nm, " z_err"}, z_err, er);
      $display("[TB] %s: z=%0d tag=%0d err=%0d", nm, z, z_tag, z_err);
   endtask

   initial begin
      //            tag s   x   y   z  err
      vecs[0]  = '{0, 0,  7,  6,  2, 0};
      vecs[1]  = '{1, 1,  3,  5,  9, 0};
      vecs[2]  = '{1, 1,  0,  0,  0, 0};
      vecs[3]  = '{0, 0, 10, 10,  9, 0};
      vecs[4]  = '{0, 0, 12,  1,  0, 1};
      vecs[5]  = '{0, 0,  1,  1,  2, 0};
      vecs[6]  = '{1, 1,  0, 10,  1, 0};
      vecs[7]  = '{0, 0,  5,  5, 10, 0};
      vecs[8]  = '{1, 0,  5,  6,  0, 0};
      vecs[9]  = '{0, 1, 10,  3,  7, 0};
      vecs[10] = '{1, 1,  3, 15,  0, 1};
      vecs[11] = '{0, 0, 15, 15,  0, 1};
      vecs[12] = '{1, 1,  4,  4,  0, 0};

      // reset state, with both requesters asking
      rst = 1'b1; z_ready = 1'b1; idle();
      r0_valid = 1'b1; r1_valid = 1'b1;
      step(); step();
      chk("reset r0_ready", r0_ready, 0);
      chk("reset r1_ready", r1_ready, 0);
      chk("reset z_valid", z_valid, 0);
      chk("reset z", z, 0);
      chk("reset z_tag", z_tag, 0);
      chk("reset z_err", z_err, 0);
      rst = 1'b0; idle();

      // table: one op per cycle, results three cycles later
      for (int i = 0; i < N + 3; i++) begin
         step(); idle();
         if (i < N) drive(vecs[i].tag, vecs[i].s, vecs[i].x, vecs[i].y);
         #1;
         if (i < N) chk($sformatf("vec%0d ready", i),
                        (vecs[i].tag == 0) ? r0_ready : r1_ready, 1);
         if (i >= 3) chk_z($sformatf("vec%0d", i - 3), vecs[i-3].z, vecs[i-3].tag, vecs[i-3].err);
         else        chk($sformatf("vec fill%0d z_valid", i), z_valid, 0);
      end

      // contention: strict alternation starting from r0
      for (int i = 0; i < 8; i++) begin
         step(); idle();
         if (i < 4) begin
            drive(0, 0, 1, 2);
            drive(1, 1, 9, 2);
         end
         #1;
         if (i < 4) begin
            chk($sformatf("rr%0d r0_ready", i), r0_ready, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("rr%0d r1_ready", i), r1_ready, (i % 2 == 1) ? 1 : 0);
         end
         if (i >= 3 && i < 7)
            chk_z($sformatf("rr res%0d", i - 3), ((i - 3) % 2 == 1) ? 7 : 3, (i - 3) % 2, 0);
         if (i == 7) chk("rr drained z_valid", z_valid, 0);
      end

      // backpressure: three ops in flight, output stalled 5 cycles
      for (int i = 0; i < 12; i++) begin
         step(); idle();
         z_ready = !(i >= 3 && i <= 7);
         if (i < 3) drive(0, 0, i + 1, i + 1);
         if (i >= 3 && i <= 7) drive(1, 0, 1, 1);
         #1;
         if (i < 3) chk($sformatf("stall fill%0d r0_ready", i), r0_ready, 1);
         if (i >= 3 && i <= 7) begin
            chk($sformatf("stall%0d r1_ready", i), r1_ready, 0);
            chk($sformatf("stall%0d r0_ready", i), r0_ready, 0);
         end
         if (i >= 3 && i <= 8) chk_z($sformatf("stall hold%0d", i), 2, 0, 0);
         if (i == 9)  chk_z("drain1", 4, 0, 0);
         if (i == 10) chk_z("drain2", 6, 0, 0);
         if (i == 11) chk("drain end z_valid", z_valid, 0);
      end
      z_ready = 1'b1;

      // reset with two ops in flight, then r1-first grant and pointer at r0
      for (int i = 0; i < 9; i++) begin
         step(); idle();
         rst = (i == 2);
         if (i < 2) drive(0, 0, i + 1, i + 1);
         if (i == 2) begin r0_valid = 1'b1; r1_valid = 1'b1; end
         if (i == 3) drive(1, 0, 4, 5);
         if (i == 4) begin drive(0, 0, 1, 2); drive(1, 0, 6, 6); end
         #1;
         if (i == 2) begin
            chk("rst r0_ready", r0_ready, 0);
            chk("rst r1_ready", r1_ready, 0);
         end
         if (i == 3) chk("post-rst r1_ready", r1_ready, 1);
         if (i == 4) begin
            chk("post-rst ptr r0_ready", r0_ready, 1);
            chk("post-rst ptr r1_ready", r1_ready, 0);
         end
         if (i >= 2 && i <= 5) chk($sformatf("rst flush%0d z_valid", i), z_valid, 0);
         if (i == 6) chk_z("post-rst r1 result", 9, 1, 0);
         if (i == 7) chk_z("post-rst r0 result", 3, 0, 0);
         if (i == 8) chk("post-rst end z_valid", z_valid, 0);
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end
endmodule
